// File: rtl/aer_spike_arbiter.sv
// aer_spike_arbiter
// Merges per-channel spike pulses into a single serial AER event stream
// {channel_id, timestamp} over a valid/ready link. Each channel owns one
// pending slot holding the timestamp of its oldest unsent spike. Slots are
// served round-robin. A spike that arrives while its slot is still full is
// dropped and counted.
//
// Ports
//   clk, rst_n   system clock, asynchronous active-low reset
//   ts_tick      advance the free-running timestamp this cycle
//   arb_en       allow new grants (never aborts an event already presented)
//   spike_in     per-channel spike strobes, one event per high cycle
//   aer_data     {channel_id, timestamp} of the presented event
//   aer_valid    aer_data holds an event
//   aer_ready    downstream accepts when aer_valid & aer_ready
//   pending_any  OR of all pending slots
//   drop_pulse   one-cycle pulse after an edge that lost at least one spike
//   drop_count   saturating count of lost spikes
module aer_spike_arbiter #(
  parameter int unsigned NUM_CH = 16,
  parameter int unsigned CH_W   = 4,
  parameter int unsigned TS_W   = 20,
  parameter int unsigned DROP_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ts_tick,
  input  logic                 arb_en,
  input  logic [NUM_CH-1:0]    spike_in,
  output logic [CH_W+TS_W-1:0] aer_data,
  output logic                 aer_valid,
  input  logic                 aer_ready,
  output logic                 pending_any,
  output logic                 drop_pulse,
  output logic [DROP_W-1:0]    drop_count
);

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [TS_W-1:0]       r_ts;
  logic [NUM_CH-1:0]     r_pending;
  logic [TS_W-1:0]       r_stamp [NUM_CH];
  logic [CH_W-1:0]       r_last_grant;
  logic [CH_W+TS_W-1:0]  r_data;
  logic                  r_drop_pulse;
  logic [DROP_W-1:0]     r_drop_count;

  logic                  w_load;
  logic                  w_found;
  logic [CH_W-1:0]       w_idx;
  logic [CH_W-1:0]       w_winner;
  logic [NUM_CH-1:0]     w_grant_vec;
  logic [NUM_CH-1:0]     w_drop_vec;
  logic [CH_W:0]         w_drop_num;
  logic [DROP_W:0]       w_drop_sum;
  logic [DROP_W-1:0]     w_drop_count_nxt;

  assign pending_any = |r_pending;
  assign aer_valid   = (r_state == ST_SEND);
  assign aer_data    = r_data;
  assign drop_pulse  = r_drop_pulse;
  assign drop_count  = r_drop_count;

  // Round-robin search starting just after the last granted channel.
  // NUM_CH is a power of two, so truncation to CH_W bits is the modulo.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      w_idx = CH_W'(r_last_grant + k);
      if (!w_found && r_pending[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (arb_en && w_found) begin
          w_load      = 1'b1;
          w_state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        // Back-to-back: the accepting edge may load the next winner.
        if (aer_ready) begin
          if (arb_en && w_found) begin
            w_load = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_grant_vec = w_load ? (NUM_CH'(1) << w_winner) : '0;
  // A slot being granted on this edge frees up in time to take the new spike.
  assign w_drop_vec  = spike_in & r_pending & ~w_grant_vec;

  always_comb begin
    w_drop_num = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      w_drop_num = w_drop_num + (CH_W+1)'(w_drop_vec[i]);
    end
    w_drop_sum       = {1'b0, r_drop_count} + (DROP_W+1)'(w_drop_num);
    w_drop_count_nxt = w_drop_sum[DROP_W] ? '1 : w_drop_sum[DROP_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_ts         <= '0;
      r_pending    <= '0;
      r_last_grant <= '1;
      r_data       <= '0;
      r_drop_pulse <= 1'b0;
      r_drop_count <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        r_stamp[i] <= '0;
      end
    end else begin
      r_state      <= w_state_nxt;
      r_drop_pulse <= |w_drop_vec;
      r_drop_count <= w_drop_count_nxt;
      if (ts_tick) begin
        r_ts <= r_ts + TS_W'(1);
      end
      if (w_load) begin
        r_last_grant <= w_winner;
        r_data       <= {w_winner, r_stamp[w_winner]};
      end
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (spike_in[i] && !w_drop_vec[i]) begin
          r_pending[i] <= 1'b1;
          r_stamp[i]   <= r_ts;
        end else if (w_grant_vec[i]) begin
          r_pending[i] <= 1'b0;
        end
      end
    end
  end

endmodule
